// File: rtl/pwm_multi_if.sv
// pwm_multi_if: bundles the sample/control inputs and PWM outputs of pwm_multi.
//   master: producer side (mixer/wave-shaper), drives start/sample_in/mode/enable
//   slave : the PWM block, drives pwm_out/period_start
// Parameters WIDTH and CHANNELS must match the attached pwm_multi instance.
interface pwm_multi_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    logic                      start;
    logic [CHANNELS*WIDTH-1:0] sample_in;
    logic                      mode;
    logic                      enable;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_start;

    modport master (
        output start,
        output sample_in,
        output mode,
        output enable,
        input  pwm_out,
        input  period_start
    );

    modport slave (
        input  start,
        input  sample_in,
        input  mode,
        input  enable,
        output pwm_out,
        output period_start
    );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with edge- and centre-aligned modes.
// Duty samples are captured into per-channel shadow registers on start and moved
// to the active compare registers only at a period boundary (or every cycle while
// disabled), so an update never disturbs the period in progress. All channels
// share one period counter.
// Ports:
//   clk              clock
//   n_rst            asynchronous active-low reset
//   bus.start        one-cycle strobe capturing bus.sample_in for all channels
//   bus.sample_in    channel k duty in bits [k*WIDTH +: WIDTH]
//   bus.mode         0 = edge-aligned, 1 = centre-aligned (applied at load edges)
//   bus.enable       1 = run, 0 = hold counter at 0 with outputs low
//   bus.pwm_out      registered PWM outputs, one per channel
//   bus.period_start registered pulse on the first output cycle of each period
module pwm_multi #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input logic        clk,
    input logic        n_rst,
    pwm_multi_if.slave bus
);
    localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    logic [WIDTH-1:0]                counter_q, counter_d;
    logic                            dir_up_q, dir_up_d;
    logic                            mode_q, mode_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  active_q, active_d;
    logic [CHANNELS-1:0]             pwm_out_q, pwm_out_d;
    logic                            period_start_q, period_start_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  samples;
    logic                            load;

    assign samples = bus.sample_in;

    // Counter sequencing. mode_q only changes at a load edge (counter reaching 0),
    // so a centre-to-edge switch always finishes the down-count first.
    always_comb begin
        counter_d = counter_q;
        dir_up_d  = dir_up_q;
        if (!bus.enable) begin
            counter_d = '0;
            dir_up_d  = 1'b1;
        end else if (!mode_q) begin
            // Edge-aligned: natural wrap from CntMax to 0.
            counter_d = counter_q + CntOne;
            dir_up_d  = 1'b1;
        end else if (dir_up_q) begin
            if (counter_q == CntMax) begin
                counter_d = CntMax - CntOne;
                dir_up_d  = 1'b0;
            end else begin
                counter_d = counter_q + CntOne;
            end
        end else begin
            // Down-count ends at 1 -> 0; <= also recovers if ever at 0 going down.
            if (counter_q <= CntOne) begin
                counter_d = '0;
                dir_up_d  = 1'b1;
            end else begin
                counter_d = counter_q - CntOne;
            end
        end
    end

    // Period boundary: counter arriving at 0, or any cycle while idle.
    assign load = !bus.enable || ((counter_d == '0) && (counter_q != '0));

    assign mode_d         = load ? bus.mode : mode_q;
    assign period_start_d = bus.enable && (counter_q == '0) && dir_up_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        // shadow_d already carries a same-cycle start, so it wins at a load edge.
        assign shadow_d[k]  = bus.start ? samples[k] : shadow_q[k];
        assign active_d[k]  = load ? shadow_d[k] : active_q[k];
        assign pwm_out_d[k] = bus.enable && (counter_q < active_q[k]);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            counter_q      <= '0;
            dir_up_q       <= 1'b1;
            mode_q         <= 1'b0;
            shadow_q       <= '0;
            active_q       <= '0;
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            dir_up_q       <= dir_up_d;
            mode_q         <= mode_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.pwm_out      = pwm_out_q;
    assign bus.period_start = period_start_q;
endmodule
